// File: rtl/stack_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stack_ctrl_pkg
// Shared encodings for the stack frame controller:
//   cmd_e    - command opcodes on the cmd port
//   sp_op_e  - stack-pointer control codes on the sp_op port
//   state_e  - sequencer state encoding
// ---------------------------------------------------------------------------
package stack_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_PUSH = 2'd0,
        CMD_POP  = 2'd1,
        CMD_CALL = 2'd2,
        CMD_RET  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        SP_INC  = 2'd0,
        SP_DEC  = 2'd1,
        SP_LOAD = 2'd2,
        SP_HOLD = 2'd3
    } sp_op_e;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_PUSH       = 4'd1,
        ST_POP        = 4'd2,
        ST_CALL_RA    = 4'd3,
        ST_CALL_BP    = 4'd4,
        ST_CALL_SETBP = 4'd5,
        ST_RET_SP     = 4'd6,
        ST_RET_BP     = 4'd7,
        ST_RET_RA     = 4'd8,
        ST_DONE       = 4'd9
    } state_e;

endpackage

// File: rtl/stack_bounds_check.sv
// ---------------------------------------------------------------------------
// stack_bounds_check
// Purely combinational bounds checker. The stack grows downward from
// STACK_TOP; all arithmetic wraps modulo 2^16.
//   sp, bp    in  current stack / base pointer
//   push_err  out  stack already holds MAX_DEPTH entries
//   pop_err   out  stack empty
//   call_err  out  fewer than two free slots (return address + saved bp)
//   ret_err   out  current frame holds fewer than two entries
// ---------------------------------------------------------------------------
module stack_bounds_check #(
    parameter logic [15:0] STACK_TOP   = 16'h0000,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic [15:0] sp,
    input  logic [15:0] bp,
    output logic        push_err,
    output logic        pop_err,
    output logic        call_err,
    output logic        ret_err
);

    localparam logic [15:0] MAX_DEPTH = STACK_TOP - STACK_LIMIT;

    logic [15:0] depth;
    logic [15:0] frame_depth;

    assign depth       = STACK_TOP - sp;
    assign frame_depth = STACK_TOP - bp;

    assign push_err = (depth == MAX_DEPTH);
    assign pop_err  = (depth == 16'd0);
    // Compared as depth + 2 > MAX_DEPTH in 17 bits so a tiny MAX_DEPTH
    // cannot wrap the threshold around.
    assign call_err = (({1'b0, depth} + 17'd2) > {1'b0, MAX_DEPTH});
    assign ret_err  = (frame_depth < 16'd2);

endmodule

// File: rtl/stack_frame_controller.sv
// ---------------------------------------------------------------------------
// stack_frame_controller
// Sequences PUSH / POP / CALL / RET against an external SP/BP register pair
// and a single-port memory with a ready handshake.
//   clock, reset            sole clock; asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only while IDLE)
//   cmd, cmd_data           opcode and PUSH value / CALL return address
//   sp, bp                  current pointer values from the register pair
//   sp_op, sp_wdata         SP control: inc / dec / load / hold
//   bp_write, bp_wdata      BP write strobe and data
//   mem_req/we/addr/wdata   memory request, held until mem_ready
//   mem_ready, mem_rdata    memory response
//   done, error, result     completion pulse, error flag, POP / RET value
// ---------------------------------------------------------------------------
module stack_frame_controller
    import stack_ctrl_pkg::*;
#(
    parameter logic [15:0] STACK_TOP   = 16'h0000,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd,
    input  logic [15:0] cmd_data,
    input  logic [15:0] sp,
    input  logic [15:0] bp,
    output logic [1:0]  sp_op,
    output logic [15:0] sp_wdata,
    output logic        bp_write,
    output logic [15:0] bp_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        done,
    output logic        error,
    output logic [15:0] result
);

    state_e      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic        error_q, error_d;
    logic [15:0] result_q, result_d;

    logic push_err, pop_err, call_err, ret_err;
    logic cmd_err;
    logic accept;
    logic [15:0] sp_m1;

    stack_bounds_check #(
        .STACK_TOP  (STACK_TOP),
        .STACK_LIMIT(STACK_LIMIT)
    ) u_bounds (
        .sp      (sp),
        .bp      (bp),
        .push_err(push_err),
        .pop_err (pop_err),
        .call_err(call_err),
        .ret_err (ret_err)
    );

    // Gated by reset so ready is low while reset is held, even though the
    // state register already reads IDLE.
    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign sp_m1     = sp - 16'd1;

    assign done   = (state_q == ST_DONE);
    assign error  = error_q;
    assign result = result_q;

    always_comb begin
        cmd_err = 1'b0;
        case (cmd_e'(cmd))
            CMD_PUSH: cmd_err = push_err;
            CMD_POP:  cmd_err = pop_err;
            CMD_CALL: cmd_err = call_err;
            CMD_RET:  cmd_err = ret_err;
            default:  cmd_err = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data_q   <= 16'd0;
            error_q  <= 1'b0;
            result_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        error_d  = error_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = cmd_data;
                    error_d = cmd_err;
                    if (cmd_err) begin
                        state_d = ST_DONE;
                    end else begin
                        case (cmd_e'(cmd))
                            CMD_PUSH: state_d = ST_PUSH;
                            CMD_POP:  state_d = ST_POP;
                            CMD_CALL: state_d = ST_CALL_RA;
                            default:  state_d = ST_RET_SP;
                        endcase
                    end
                end
            end
            ST_PUSH:    if (mem_ready) state_d = ST_DONE;
            ST_POP: begin
                if (mem_ready) begin
                    result_d = mem_rdata;
                    state_d  = ST_DONE;
                end
            end
            ST_CALL_RA:    if (mem_ready) state_d = ST_CALL_BP;
            ST_CALL_BP:    if (mem_ready) state_d = ST_CALL_SETBP;
            ST_CALL_SETBP: state_d = ST_DONE;
            ST_RET_SP:     state_d = ST_RET_BP;
            ST_RET_BP:     if (mem_ready) state_d = ST_RET_RA;
            ST_RET_RA: begin
                if (mem_ready) begin
                    result_d = mem_rdata;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic. Memory address/data come from sp/bp of the current cycle;
    // SP is held while a request stalls, so the request stays stable.
    always_comb begin
        sp_op     = SP_HOLD;
        sp_wdata  = 16'd0;
        bp_write  = 1'b0;
        bp_wdata  = 16'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'd0;
        mem_wdata = 16'd0;
        unique case (state_q)
            ST_PUSH, ST_CALL_RA: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_m1;
                mem_wdata = data_q;
                if (mem_ready) sp_op = SP_DEC;
            end
            ST_CALL_BP: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_m1;
                mem_wdata = bp;
                if (mem_ready) sp_op = SP_DEC;
            end
            ST_CALL_SETBP: begin
                bp_write = 1'b1;
                bp_wdata = sp;
            end
            ST_RET_SP: begin
                sp_op    = SP_LOAD;
                sp_wdata = bp;
            end
            ST_RET_BP: begin
                mem_req  = 1'b1;
                mem_addr = sp;
                if (mem_ready) begin
                    bp_write = 1'b1;
                    bp_wdata = mem_rdata;
                    sp_op    = SP_INC;
                end
            end
            ST_POP, ST_RET_RA: begin
                mem_req  = 1'b1;
                mem_addr = sp;
                if (mem_ready) sp_op = SP_INC;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_stack_frame_controller.sv
module tb_stack_frame_controller;
    import stack_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd;
    logic [15:0] cmd_data;
    logic [15:0] sp_r, bp_r;
    logic [1:0]  sp_op;
    logic [15:0] sp_wdata;
    logic        bp_write;
    logic [15:0] bp_wdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        done, error;
    logic [15:0] result;

    always #5 clock = ~clock;

    stack_frame_controller #(
        .STACK_TOP  (16'h0000),
        .STACK_LIMIT(16'hFF00)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd      (cmd),
        .cmd_data (cmd_data),
        .sp       (sp_r),
        .bp       (bp_r),
        .sp_op    (sp_op),
        .sp_wdata (sp_wdata),
        .bp_write (bp_write),
        .bp_wdata (bp_wdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .done     (done),
        .error    (error),
        .result   (result)
    );

    // ---------------- environment: SP/BP register pair ----------------
    logic        preset_en = 1'b0;
    logic [15:0] preset_sp, preset_bp;

    always @(posedge clock) begin
        if (preset_en) begin
            sp_r <= preset_sp;
            bp_r <= preset_bp;
        end else begin
            case (sp_op)
                2'd0:    sp_r <= sp_r + 16'd1;
                2'd1:    sp_r <= sp_r - 16'd1;
                2'd2:    sp_r <= sp_wdata;
                default: ;
            endcase
            if (bp_write) bp_r <= bp_wdata;
        end
    end

    // ---------------- environment: memory with programmable wait ----------------
    // Unwritten locations read back as the inverted address.
    logic [15:0] mem    [0:65535];
    bit          mem_wr [0:65535];
    int          mem_delay = 0;
    int          wait_cnt;

    assign mem_rdata = mem_wr[mem_addr] ? mem[mem_addr] : ~mem_addr;
    assign mem_ready = mem_req && (wait_cnt >= mem_delay);

    always @(posedge clock) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr]    <= mem_wdata;
            mem_wr[mem_addr] <= 1'b1;
        end
    end

    // ---------------- monitor counters ----------------
    int          hs_cnt, bpw_cnt, acc_cnt, hold_viol;
    logic        stall_prev = 1'b0;
    logic [15:0] s_addr, s_wdata;
    logic        s_we;

    always @(posedge clock) begin
        if (mem_req && mem_ready)  hs_cnt  <= hs_cnt + 1;
        if (bp_write)              bpw_cnt <= bpw_cnt + 1;
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
        if (stall_prev && mem_req &&
            (mem_addr != s_addr || mem_we != s_we || mem_wdata != s_wdata))
            hold_viol <= hold_viol + 1;
        stall_prev <= mem_req && !mem_ready;
        s_addr     <= mem_addr;
        s_we       <= mem_we;
        s_wdata    <= mem_wdata;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] data;
        logic [15:0] sp0;
        logic [15:0] bp0;
        int          delay;
        logic        exp_err;
        logic        chk_res;
        logic [15:0] exp_res;
        logic [15:0] exp_sp;
        logic [15:0] exp_bp;
        int          exp_lat;
        int          exp_mem;
        int          exp_bpw;
    } vec_t;

    function automatic vec_t mk(logic [1:0] c, logic [15:0] d, logic [15:0] s0, logic [15:0] b0,
                                int dl, logic er, logic cr, logic [15:0] rs, logic [15:0] s1,
                                logic [15:0] b1, int lt, int mm, int bw);
        vec_t v;
        v.cmd = c; v.data = d; v.sp0 = s0; v.bp0 = b0; v.delay = dl;
        v.exp_err = er; v.chk_res = cr; v.exp_res = rs; v.exp_sp = s1; v.exp_bp = b1;
        v.exp_lat = lt; v.exp_mem = mm; v.exp_bpw = bw;
        return v;
    endfunction

    vec_t exp_q[$];
    vec_t vecs[13];

    task automatic preset(input logic [15:0] s, input logic [15:0] b, input int dl);
        @(negedge clock);
        preset_sp = s; preset_bp = b; preset_en = 1'b1; mem_delay = dl;
        @(negedge clock);
        preset_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat, hs0, bpw0, hv0;
        vec_t e;
        preset(v.sp0, v.bp0, v.delay);
        hs0 = hs_cnt; bpw0 = bpw_cnt; hv0 = hold_viol;
        check($sformatf("v%0d ready", idx), cmd_ready, 1);
        cmd = v.cmd; cmd_data = v.data; cmd_valid = 1'b1;
        exp_q.push_back(v);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d done_seen", idx), done, 1);
        check($sformatf("v%0d latency", idx), lat, e.exp_lat);
        check($sformatf("v%0d error", idx), error, e.exp_err);
        if (e.chk_res) check($sformatf("v%0d result", idx), result, e.exp_res);
        check($sformatf("v%0d mem_ops", idx), hs_cnt - hs0, e.exp_mem);
        check($sformatf("v%0d bp_writes", idx), bpw_cnt - bpw0, e.exp_bpw);
        check($sformatf("v%0d req_stable", idx), hold_viol - hv0, 0);
        check($sformatf("v%0d sp", idx), sp_r, e.exp_sp);
        check($sformatf("v%0d bp", idx), bp_r, e.exp_bp);
        check($sformatf("v%0d busy_ready", idx), cmd_ready, 0);
        check($sformatf("v%0d done_sp_op", idx), sp_op, 3);
        @(posedge clock); #1;
        check($sformatf("v%0d done_pulse", idx), done, 0);
        check($sformatf("v%0d error_kept", idx), error, e.exp_err);
        $display("vec %0d cmd=%0d sp0=%h bp0=%h -> err=%0d res=%h sp=%h bp=%h lat=%0d",
                 idx, v.cmd, v.sp0, v.bp0, error, result, sp_r, bp_r, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bpw0, acc0;
        //                 cmd       data      sp0       bp0   dly err chk res       sp        bp     lat mem bpw
        vecs[0]  = mk(CMD_PUSH, 16'hBEEF, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 2, 1, 0);
        vecs[1]  = mk(CMD_POP,  16'h0000, 16'hFFFF, 16'h0000, 3, 0, 1, 16'hBEEF, 16'h0000, 16'h0000, 5, 1, 0);
        vecs[2]  = mk(CMD_CALL, 16'h0123, 16'hFFF0, 16'hFFF8, 0, 0, 0, 16'h0000, 16'hFFEE, 16'hFFEE, 4, 2, 1);
        vecs[3]  = mk(CMD_RET,  16'h0000, 16'hFFEE, 16'hFFEE, 0, 0, 1, 16'h0123, 16'hFFF0, 16'hFFF8, 4, 2, 1);
        vecs[4]  = mk(CMD_PUSH, 16'h1111, 16'hFF00, 16'h0000, 0, 1, 0, 16'h0000, 16'hFF00, 16'h0000, 1, 0, 0);
        vecs[5]  = mk(CMD_POP,  16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
        vecs[6]  = mk(CMD_CALL, 16'h2222, 16'hFF01, 16'h0000, 0, 1, 0, 16'h0000, 16'hFF01, 16'h0000, 1, 0, 0);
        vecs[7]  = mk(CMD_PUSH, 16'h1234, 16'hFF01, 16'h0000, 2, 0, 0, 16'h0000, 16'hFF00, 16'h0000, 4, 1, 0);
        vecs[8]  = mk(CMD_CALL, 16'hABCD, 16'hFF02, 16'h0000, 1, 0, 0, 16'h0000, 16'hFF00, 16'hFF00, 6, 2, 1);
        vecs[9]  = mk(CMD_RET,  16'h0000, 16'h1234, 16'hFFFF, 0, 1, 0, 16'h0000, 16'h1234, 16'hFFFF, 1, 0, 0);
        vecs[10] = mk(CMD_RET,  16'h0000, 16'h5555, 16'hFFFE, 0, 0, 1, 16'hBEEF, 16'h0000, 16'h0001, 4, 2, 1);
        vecs[11] = mk(CMD_RET,  16'h0000, 16'hFF00, 16'hFF00, 0, 0, 1, 16'hABCD, 16'hFF02, 16'h0000, 4, 2, 1);
        vecs[12] = mk(CMD_POP,  16'h0000, 16'hFF02, 16'h0000, 0, 0, 1, 16'h00FD, 16'hFF03, 16'h0000, 2, 1, 0);

        reset = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; cmd_data = 16'd0;
        preset_sp = 16'd0; preset_bp = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst cmd_ready", cmd_ready, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst result", result, 0);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst sp_op", sp_op, 3);
        check("rst sp_wdata", sp_wdata, 0);
        check("rst bp_write", bp_write, 0);
        check("rst bp_wdata", bp_wdata, 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("post-reset cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        check("mem FFEF ret addr", mem[16'hFFEF], 16'h0123);
        check("mem FFEE saved bp", mem[16'hFFEE], 16'hFFF8);
        check("mem FFFF push", mem[16'hFFFF], 16'hBEEF);

        // Reset in CALL_BP while the request is stalled.
        preset(16'hFFF0, 16'hFFF8, 4);
        cmd = CMD_CALL; cmd_data = 16'h7777; cmd_valid = 1'b1;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        n = 0;
        begin
            int hs0;
            hs0 = hs_cnt - 0;
            n = 0;
            while (n < 50 && !(mem_req && mem_wdata == 16'hFFF8)) begin
                @(posedge clock); #1;
                n++;
            end
            check("abort in CALL_BP", mem_req && (mem_wdata == 16'hFFF8), 1);
            check("abort ra written", hs_cnt - hs0 >= 1, 1);
        end
        bpw0 = bpw_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("abort mem_req async", mem_req, 0);
        check("abort bp_write", bp_write, 0);
        check("abort cmd_ready", cmd_ready, 0);
        check("abort sp_op", sp_op, 3);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        mem_delay = 0;
        @(posedge clock); #1;
        check("abort ready after release", cmd_ready, 1);
        check("abort no bp_write", bpw_cnt - bpw0, 0);
        check("abort bp unchanged", bp_r, 16'hFFF8);
        check("abort not resumed", mem_req, 0);
        $display("abort: reset in CALL_BP, bp=%h ready=%0d", bp_r, cmd_ready);

        // cmd_valid held high through a CALL: only one acceptance.
        preset(16'hFFF0, 16'hFFF8, 0);
        acc0 = acc_cnt;
        cmd = CMD_CALL; cmd_data = 16'h4321; cmd_valid = 1'b1;
        @(posedge clock); #1;
        n = 1;
        while (!done && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("hold done_seen", done, 1);
        check("hold latency", n, 4);
        check("hold one accept", acc_cnt - acc0, 1);
        check("hold ready low in done", cmd_ready, 0);
        @(negedge clock);
        cmd_valid = 1'b0;
        @(posedge clock); #1;
        check("hold accepts after", acc_cnt - acc0, 1);
        check("hold ready idle", cmd_ready, 1);
        check("hold sp", sp_r, 16'hFFEE);
        $display("hold: accepts=%0d sp=%h bp=%h", acc_cnt - acc0, sp_r, bp_r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_frame_controller.md
STACK_FRAME_CONTROLLER -- requirements
Module: stack_frame_controller

Interface
REQ-001 Parameter STACK_TOP, default 16'h0000: SP value of the empty stack; stack grows downward with mod-2^16 wrap.
REQ-002 Parameter STACK_LIMIT, default 16'hFF00: lowest legal SP; MAX_DEPTH = (STACK_TOP - STACK_LIMIT) mod 2^16, default 256.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-006 cmd  in  2  0=PUSH, 1=POP, 2=CALL, 3=RET.
REQ-007 cmd_data  in  16  PUSH value or CALL return address.
REQ-008 sp / bp  in  16 / 16  current stack-pointer and base-pointer register outputs.
REQ-009 sp_op / sp_wdata  out  2 / 16  stack-pointer control: 0=inc, 1=dec, 2=load, 3=hold.
REQ-010 bp_write / bp_wdata  out  1 / 16  base-pointer write strobe and data.
REQ-011 mem_req, mem_we, mem_addr[16], mem_wdata[16]  out  memory request; mem_ready, mem_rdata[16]  in.
REQ-012 done / error / result  out  1 / 1 / 16  completion pulse, error flag, POP value or RET return address.

Function
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-014 depth = (STACK_TOP - sp) mod 2^16; frame depth = (STACK_TOP - bp) mod 2^16.
REQ-015 Bounds checks at acceptance: PUSH errors if depth == MAX_DEPTH; POP if depth == 0; CALL if depth > MAX_DEPTH-2; RET if frame depth < 2.
REQ-016 An erroring command SHALL go straight to DONE with error=1 and no memory, SP or BP side effects.
REQ-017 States: IDLE, PUSH, POP, CALL_RA, CALL_BP, CALL_SETBP, RET_SP, RET_BP, RET_RA, DONE.
REQ-018 PUSH: mem write at sp-1 with cmd_data; on mem_ready sp_op=dec; go to DONE.
REQ-019 POP: mem read at sp; on mem_ready capture mem_rdata into result, sp_op=inc; go to DONE.
REQ-020 CALL: CALL_RA writes cmd_data (latched at accept) at sp-1 and decrements; CALL_BP writes bp at sp-1 and decrements; CALL_SETBP asserts bp_write with bp_wdata=sp; go to DONE.
REQ-021 RET: RET_SP sets sp_op=load with sp_wdata=bp; RET_BP reads at sp and on mem_ready asserts bp_write with bp_wdata=mem_rdata and sp_op=inc; RET_RA reads at sp and on mem_ready sets result=mem_rdata and sp_op=inc; go to DONE.
REQ-022 Each state SHALL use the sp/bp input values of its own cycle, which reflect the previous state's update.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata SHALL stay constant until the cycle in which mem_ready=1; mem_ready is ignored while mem_req=0.
REQ-024 sp_op SHALL be hold (3) and bp_write 0 in every cycle not listed above.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; error and result stay valid until the next acceptance.
REQ-026 Zero-wait latency from accept edge to done: PUSH/POP 2 cycles, CALL 4 cycles, RET 4 cycles.
REQ-027 cmd_valid during a busy sequence SHALL be ignored and not queued.

Reset
REQ-028 Reset SHALL force IDLE immediately, including mid-sequence.
REQ-029 During reset: cmd_ready=0, done=0, error=0, result=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, sp_op=3, sp_wdata=0, bp_write=0, bp_wdata=0.
REQ-030 cmd_ready SHALL rise in the first cycle after reset deasserts.
REQ-031 A sequence aborted by reset SHALL NOT be resumed; SP/BP consistency is restored by their own reset.

Structure
REQ-032 Package stack_ctrl_pkg SHALL hold the cmd encodings, sp_op encodings and state encoding.
REQ-033 A combinational sub-module stack_bounds_check SHALL compute depth, frame depth and the four error conditions.

Verification
REQ-034 After reset with sp=0000, PUSH 16'hBEEF and mem_ready tied high -> write at FFFF, one sp_op=dec cycle, done 2 cycles after accept, error=0.
REQ-035 POP at sp=FFFF with mem_rdata=BEEF and mem_ready delayed 3 cycles -> address held for 3 cycles, result=BEEF, sp_op=inc, error=0.
REQ-036 CALL 16'h0123 at sp=FFF0, bp=FFF8 -> writes 0123@FFEF and FFF8@FFEE, then bp_write with FFEE; RET afterwards -> sp load FFEE, bp restored to FFF8, result=0123, sp returns to FFF0.
REQ-037 PUSH at sp=FF00 -> error=1, no mem_req, sp_op stays 3; POP at sp=0000 -> error=1.
REQ-038 reset asserted in CALL_BP while mem_req=1 -> mem_req drops asynchronously, bp_write never asserted, cmd_ready=1 one cycle after release.
REQ-039 cmd_valid held high through a CALL -> exactly one command accepted per IDLE visit.
